bilinear_fetch_interp: RTL
==========================

BILINEAR_FETCH_INTERP -- requirements
Module: bilinear_fetch_interp

Interface
REQ-001 Parameter ADDR_W, default 12: width of the image-memory read address.
REQ-002 Parameter DIM_W, default 7: width of the pixel coordinate and image-dimension inputs.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  request valid.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 x_int, y_int  in  DIM_W each  integer source coordinates of the top-left neighbour.
REQ-008 fx, fy  in  8 each  fractional offsets, value/256.
REQ-009 img_w, img_h  in  DIM_W each  image dimensions (1..2^DIM_W-1).
REQ-010 mem_raddr  out  ADDR_W  read address to the 1R/1W on-chip RAM; the RAM has 1-cycle registered read latency.
REQ-011 mem_rdata  in  8  RAM read data.
REQ-012 out_valid  in/out: out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_pixel  out  8  interpolated pixel.
REQ-015 pix_count  out  16  number of completed output handshakes, wraps 0xFFFF->0.

Function
REQ-016 FSM states, in order: IDLE, R0, R1, R2, R3, CAP, MAC, OUT; in_ready = 1 only in IDLE.
REQ-017 IDLE->R0 on in_valid&&in_ready; x_int, y_int, fx, fy, img_w, img_h are latched at that edge; later changes to the inputs are ignored.
REQ-018 Neighbours: x1 = x_int+1, y1 = y_int+1, subject to the edge rule in REQ-030.
REQ-019 Address = y*img_w + x, truncated to ADDR_W.
REQ-020 mem_raddr drives a00 in R0, a01 (y_int,x1) in R1, a10 (y1,x_int) in R2, and a11 (y1,x1) in R3; it is 0 in all other states.
REQ-021 mem_rdata is captured as p00 at the end of R1, p01 at the end of R2, p10 at the end of R3, and p11 at the end of CAP.
REQ-022 In MAC, with integer arithmetic and no intermediate truncation:
- top = p00*(256-fx) + p01*fx (17 bits)
- bot = p10*(256-fx) + p11*fx
- acc = top*(256-fy) + bot*fy (25 bits)
- out_pixel = (acc + 32768) >> 16, saturated to 255
out_pixel is registered at the end of MAC.
REQ-023 out_valid = 1 only in OUT, first asserted 6 clock edges after the accepting edge.
REQ-024 While out_valid=1 and out_ready=0, out_pixel SHALL hold stable and no new request is accepted.
REQ-025 OUT->IDLE on out_ready=1; pix_count increments on that same edge.
REQ-026 Throughput is one result per 8 cycles minimum, with out_ready tied high.

Reset
REQ-027 rst_n=0 at any time, including mid-request, SHALL immediately force:
- state IDLE
- in_ready=1, out_valid=0
- out_pixel=0, pix_count=0
- mem_raddr=0
- all latched coordinates and pixels = 0
REQ-028 After rst_n deasserts, the first request is accepted on the first edge with in_valid=1; an aborted request produces no output.

Configuration
REQ-029 Macro BILINEAR_EDGE_CLAMP_EN selects the edge-neighbour rule.
REQ-030 With BILINEAR_EDGE_CLAMP_EN defined, x1 = min(x_int+1, img_w-1) and y1 = min(y_int+1, img_h-1). Without it, x1 = x_int+1 and y1 = y_int+1 unclamped, and addresses wrap modulo 2^ADDR_W.

Verification
REQ-031 Request img_w=64, x=5, y=2 -> mem_raddr sequence 133, 134, 197, 198 in R0..R3.
REQ-032 Neighbours p00=10, p01=20, p10=30, p11=40, fx=fy=128 -> out_pixel=25. With fx=fy=0 -> 10. With fx=255, fy=0 -> 20.
REQ-033 img_w=img_h=64, x=y=63 with the macro -> all four addresses 4095. Without the macro -> addresses 4095, 0, 63, 64.
REQ-034 out_ready held low for 5 cycles in OUT -> out_valid and out_pixel stable, in_ready=0, pix_count unchanged. out_ready=1 -> pix_count +1 and IDLE next cycle.
REQ-035 rst_n pulsed low during R2 -> same cycle in_ready=1, out_valid=0, mem_raddr=0. The next request completes normally with a correct value.
REQ-036 Back-to-back requests with out_ready tied 1 -> out_valid asserted every 8 cycles, pix_count counts 1, 2, 3.

Source files
------------

// File: rtl/bilinear_fetch_interp_if.sv
// Request, RAM-read and result signals of the bilinear fetch/interpolate block.
// The slave modport is the block's view; the master modport is the requester/RAM side.
interface bilinear_fetch_interp_if #(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [DIM_W-1:0]  x_int;
    logic [DIM_W-1:0]  y_int;
    logic [7:0]        fx;
    logic [7:0]        fy;
    logic [DIM_W-1:0]  img_w;
    logic [DIM_W-1:0]  img_h;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_pixel;
    logic [15:0]       pix_count;

    modport slave (
        input  in_valid, x_int, y_int, fx, fy, img_w, img_h, mem_rdata, out_ready,
        output in_ready, mem_raddr, out_valid, out_pixel, pix_count
    );

    modport master (
        output in_valid, x_int, y_int, fx, fy, img_w, img_h, mem_rdata, out_ready,
        input  in_ready, mem_raddr, out_valid, out_pixel, pix_count
    );
endinterface

// File: rtl/bilinear_fetch_interp.sv
// Fetches the four neighbours of a pixel from a 1-cycle-latency RAM and blends them bilinearly.
// Define BILINEAR_EDGE_CLAMP_EN to clamp the right/bottom neighbours to the image edge.
module bilinear_fetch_interp #(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bilinear_fetch_interp_if.slave  bus
);
    localparam int PROD_W = 2 * DIM_W + 2;

    typedef enum logic [2:0] {IDLE, R0, R1, R2, R3, CAP, MAC, OUT} state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [7:0]        out_pixel_q;
    logic [15:0]       pix_count_q;
    logic [ADDR_W-1:0] mem_raddr_q;
    logic [DIM_W-1:0]  x_q, y_q, img_w_q, img_h_q;
    logic [7:0]        fx_q, fy_q;
    logic [7:0]        p00_q, p01_q, p10_q, p11_q;

    logic [DIM_W:0]    x_inc_s, y_inc_s, x1_s, y1_s;
    logic [ADDR_W-1:0] a00_s, a01_s, a10_s, a11_s;
    logic [16:0]       top_s, bot_s;
    logic [25:0]       acc_s, sum_s;
    logic [9:0]        rnd_s;
    logic [7:0]        pixel_s;

    // Row-major address; the product is kept wide and only the final sum is truncated.
    function automatic logic [ADDR_W-1:0] addr_f(input logic [DIM_W:0]   row,
                                                 input logic [DIM_W:0]   col,
                                                 input logic [DIM_W-1:0] width);
        logic [PROD_W-1:0] full;
        full = PROD_W'(row) * PROD_W'(width) + PROD_W'(col);
        return ADDR_W'(full);
    endfunction

    assign x_inc_s = {1'b0, x_q} + {{DIM_W{1'b0}}, 1'b1};
    assign y_inc_s = {1'b0, y_q} + {{DIM_W{1'b0}}, 1'b1};

`ifdef BILINEAR_EDGE_CLAMP_EN
    logic [DIM_W:0] w_m1_s, h_m1_s;
    assign w_m1_s = {1'b0, img_w_q} - {{DIM_W{1'b0}}, 1'b1};
    assign h_m1_s = {1'b0, img_h_q} - {{DIM_W{1'b0}}, 1'b1};
    assign x1_s   = (x_inc_s > w_m1_s) ? w_m1_s : x_inc_s;
    assign y1_s   = (y_inc_s > h_m1_s) ? h_m1_s : y_inc_s;
`else
    // Height only matters for clamping; it is still latched so the request state is complete.
    logic unused_s;
    assign x1_s     = x_inc_s;
    assign y1_s     = y_inc_s;
    assign unused_s = ^img_h_q;
`endif

    assign a00_s = addr_f({1'b0, bus.y_int}, {1'b0, bus.x_int}, bus.img_w);
    assign a01_s = addr_f({1'b0, y_q}, x1_s, img_w_q);
    assign a10_s = addr_f(y1_s, {1'b0, x_q}, img_w_q);
    assign a11_s = addr_f(y1_s, x1_s, img_w_q);

    // Two-stage bilinear blend with round-half-up and saturation.
    always_comb begin
        top_s = 17'(p00_q) * (17'd256 - 17'(fx_q)) + 17'(p01_q) * 17'(fx_q);
        bot_s = 17'(p10_q) * (17'd256 - 17'(fx_q)) + 17'(p11_q) * 17'(fx_q);
        acc_s = 26'(top_s) * (26'd256 - 26'(fy_q)) + 26'(bot_s) * 26'(fy_q);
        sum_s = acc_s + 26'd32768;
        rnd_s = 10'(sum_s >> 16);
        if (rnd_s > 10'd255) begin
            pixel_s = 8'd255;
        end else begin
            pixel_s = rnd_s[7:0];
        end
    end

    // Sequencer: four RAM reads, one capture slot for the last read, blend, then hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_pixel_q <= 8'd0;
            pix_count_q <= 16'd0;
            mem_raddr_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            img_w_q     <= '0;
            img_h_q     <= '0;
            fx_q        <= 8'd0;
            fy_q        <= 8'd0;
            p00_q       <= 8'd0;
            p01_q       <= 8'd0;
            p10_q       <= 8'd0;
            p11_q       <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        x_q         <= bus.x_int;
                        y_q         <= bus.y_int;
                        img_w_q     <= bus.img_w;
                        img_h_q     <= bus.img_h;
                        fx_q        <= bus.fx;
                        fy_q        <= bus.fy;
                        mem_raddr_q <= a00_s;
                        in_ready_q  <= 1'b0;
                        state_q     <= R0;
                    end
                end
                R0: begin
                    mem_raddr_q <= a01_s;
                    state_q     <= R1;
                end
                R1: begin
                    p00_q       <= bus.mem_rdata;
                    mem_raddr_q <= a10_s;
                    state_q     <= R2;
                end
                R2: begin
                    p01_q       <= bus.mem_rdata;
                    mem_raddr_q <= a11_s;
                    state_q     <= R3;
                end
                R3: begin
                    p10_q       <= bus.mem_rdata;
                    mem_raddr_q <= '0;
                    state_q     <= CAP;
                end
                CAP: begin
                    p11_q   <= bus.mem_rdata;
                    state_q <= MAC;
                end
                MAC: begin
                    out_pixel_q <= pixel_s;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        pix_count_q <= pix_count_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    mem_raddr_q <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.pix_count = pix_count_q;
    assign bus.mem_raddr = mem_raddr_q;
endmodule
